hamming_secded_decoder: RTL and testbench

Parametrised, pipelined SEC-DED Hamming decoder for DATA_W-bit payloads. It extends the 12-bit single-error-correcting code with an overall parity bit, so it can detect double errors. It accepts one codeword per cycle over a valid/ready stream and returns corrected data with error status and position. It keeps saturating corrected and uncorrectable error counters for status/CSR readout.

---
 rtl/hamming_secded_decoder.sv | 168 ++++++++++++++++
 tb/tb_hamming_secded_decoder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SEC-DED Hamming decoder with saturating error counters.
// Optional HAMMING_ERR_LOG_EN adds a sticky capture of the first uncorrectable codeword.
module hamming_secded_decoder #(
  parameter int DATA_W = 8,
  parameter int PAR_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W+PAR_W:0] code_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     data_out,
  output logic                  err_sgl,
  output logic                  err_dbl,
  output logic [PAR_W-1:0]      err_pos,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      cnt_sgl,
  output logic [CNT_W-1:0]      cnt_dbl
`ifdef HAMMING_ERR_LOG_EN
  ,
  output logic                  err_log_valid,
  output logic [DATA_W+PAR_W:0] err_log_code
`endif
);

  localparam int CODE_W = DATA_W + PAR_W + 1;
  localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(CODE_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic int min_par(input int dw);
    int r;
    r = 0;
    for (int p = 7; p >= 1; p--)
      if ((1 << p) >= dw + p + 1) r = p;
    return r;
  endfunction

  // Hamming position holding payload bit j (j-th non-power-of-two position).
  function automatic int data_pos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 1; i < CODE_W; i++)
      if ((i & (i - 1)) != 0) begin
        if (cnt == j) pos = i;
        cnt++;
      end
    return pos;
  endfunction

  if (DATA_W < 4 || DATA_W > 64) begin : g_bad_data_w
    $error("hamming_secded_decoder: DATA_W must be within 4..64");
  end
  if (PAR_W != min_par(DATA_W)) begin : g_bad_par_w
    $error("hamming_secded_decoder: PAR_W is not the minimal check-bit count for DATA_W");
  end

  logic                  s1_valid;
  logic [CODE_W-1:0]     s1_code;
  logic [PAR_W-1:0]      s1_syn;
  logic                  s1_par;
  logic                  s1_adv;
  logic                  s2_adv;
  logic                  out_fire;
  logic [PAR_W-1:0]      syn_c;
  logic                  syn_zero;
  logic                  in_range;
  logic                  flip;
  logic                  sgl_c;
  logic                  dbl_c;
  logic [DATA_W-1:0]     s2_data;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !rst;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    syn_c = '0;
    for (int i = 1; i < CODE_W; i++)
      if (code_in[i]) syn_c = syn_c ^ PAR_W'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= code_in;
        s1_syn  <= syn_c;
        s1_par  <= ^code_in;
      end
    end
  end

  // A nonzero syndrome beyond the last real position can only come from a multi-bit error.
  assign syn_zero = (s1_syn == '0);
  assign in_range = (s1_syn <= MAX_POS);
  assign flip     = s1_par && !syn_zero && in_range;
  assign sgl_c    = s1_par && (syn_zero || in_range);
  assign dbl_c    = !syn_zero && !(s1_par && in_range);

  for (genvar j = 0; j < DATA_W; j++) begin : g_extract
    localparam int POS = data_pos(j);
    assign s2_data[j] = s1_code[POS] ^ (flip && (s1_syn == PAR_W'(POS)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      err_sgl   <= 1'b0;
      err_dbl   <= 1'b0;
      err_pos   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= s2_data;
        err_sgl  <= sgl_c;
        err_dbl  <= dbl_c;
        err_pos  <= flip ? s1_syn : '0;
      end
    end
  end

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_sgl <= '0;
      cnt_dbl <= '0;
    end else if (out_fire) begin
      if (err_sgl && cnt_sgl != CNT_MAX) cnt_sgl <= cnt_sgl + CNT_W'(1);
      if (err_dbl && cnt_dbl != CNT_MAX) cnt_dbl <= cnt_dbl + CNT_W'(1);
    end
  end

`ifdef HAMMING_ERR_LOG_EN
  logic [CODE_W-1:0] s2_code;

  always_ff @(posedge clk) begin
    if (rst) s2_code <= '0;
    else if (s2_adv && s1_valid) s2_code <= s1_code;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      err_log_valid <= 1'b0;
      err_log_code  <= '0;
    end else if (out_fire && err_dbl && !err_log_valid) begin
      err_log_valid <= 1'b1;
      err_log_code  <= s2_code;
    end
  end
`else
  // Check-bit positions of the stored codeword are only consumed by the error log.
  logic code_unused;
  assign code_unused = ^s1_code;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: directed vector table, hand-written corner sequences and
// a randomized backpressured stream scored against an encode-and-inject reference model.
module tb_hamming_secded_decoder;

  localparam int DATA_W = 8;
  localparam int PAR_W  = 4;
  localparam int CNT_W  = 2;
  localparam int CODE_W = DATA_W + PAR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [DATA_W-1:0] data;
    logic              sgl;
    logic              dbl;
    logic [PAR_W-1:0]  pos;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] code_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              err_sgl;
  logic              err_dbl;
  logic [PAR_W-1:0]  err_pos;
  logic              clr_cnt;
  logic [CNT_W-1:0]  cnt_sgl;
  logic [CNT_W-1:0]  cnt_dbl;
`ifdef HAMMING_ERR_LOG_EN
  logic              err_log_valid;
  logic [CODE_W-1:0] err_log_code;
`endif

  hamming_secded_decoder #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .code_in(code_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .err_sgl(err_sgl),
    .err_dbl(err_dbl),
    .err_pos(err_pos),
    .clr_cnt(clr_cnt),
    .cnt_sgl(cnt_sgl),
`ifdef HAMMING_ERR_LOG_EN
    .err_log_valid(err_log_valid),
    .err_log_code(err_log_code),
`endif
    .cnt_dbl(cnt_dbl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t sb[$];
  vec_t drv_exp;
  vec_t tbl[8];
  bit   mon_en = 1'b0;

  logic [CNT_W-1:0]  m_cnt_sgl = '0;
  logic [CNT_W-1:0]  m_cnt_dbl = '0;
  logic              m_log_valid = 1'b0;
  logic [CODE_W-1:0] m_log_code = '0;

  bit                hold_pending = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic              hold_sgl;
  logic              hold_dbl;
  logic [PAR_W-1:0]  hold_pos;
  vec_t              mon_front;
  bit                mon_hs;
  bit                exp_ir;
  int                occ;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    drv_exp  = v;
    code_in  = v.code;
    in_valid = 1'b1;
  endtask

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic x;
    int j;
    c = '0;
    j = 0;
    for (int p = 1; p < CODE_W; p++)
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    for (int k = 0; k < PAR_W; k++) begin
      x = 1'b0;
      for (int p = 1; p < CODE_W; p++)
        if (((p >> k) & 1) == 1 && p != (1 << k)) x = x ^ c[p];
      c[1 << k] = x;
    end
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int p = 1; p < CODE_W; p++)
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p];
        j++;
      end
    return d;
  endfunction

  // Expected result follows from what was injected, not from decoding the word.
  function automatic vec_t makeWord();
    vec_t v;
    logic [CODE_W-1:0] c;
    int nf;
    int a;
    int b;
    v.data = DATA_W'($urandom);
    c = encode(v.data);
    nf = $urandom_range(0, 2);
    a = $urandom_range(0, CODE_W - 1);
    b = $urandom_range(0, CODE_W - 2);
    if (b >= a) b++;
    v.sgl = 1'b0;
    v.dbl = 1'b0;
    v.pos = '0;
    if (nf == 1) begin
      c[a] = ~c[a];
      v.sgl = 1'b1;
      v.pos = PAR_W'(a);
    end else if (nf == 2) begin
      c[a] = ~c[a];
      c[b] = ~c[b];
      v.dbl = 1'b1;
      v.data = extract(c);
    end
    v.code = c;
    return v;
  endfunction

  // Scoreboard/monitor: sampled on the falling edge, updates model state for the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      occ = sb.size();
      checkOutput("cnt_sgl", 64'(cnt_sgl), 64'(m_cnt_sgl));
      checkOutput("cnt_dbl", 64'(cnt_dbl), 64'(m_cnt_dbl));
`ifdef HAMMING_ERR_LOG_EN
      checkOutput("log_valid", 64'(err_log_valid), 64'(m_log_valid));
      checkOutput("log_code", 64'(err_log_code), 64'(m_log_code));
`endif
      exp_ir = !rst && (occ < 2 || out_ready);
      checkOutput("in_ready", 64'(in_ready), 64'(exp_ir));
      if (occ == 0) checkOutput("idle_out_valid", 64'(out_valid), 64'(0));
      if (occ == 2) checkOutput("full_out_valid", 64'(out_valid), 64'(1));
      if (hold_pending) begin
        checkOutput("hold_valid", 64'(out_valid), 64'(1));
        checkOutput("hold_data", 64'(data_out), 64'(hold_data));
        checkOutput("hold_sgl", 64'(err_sgl), 64'(hold_sgl));
        checkOutput("hold_dbl", 64'(err_dbl), 64'(hold_dbl));
        checkOutput("hold_pos", 64'(err_pos), 64'(hold_pos));
      end
      mon_hs = !rst && out_valid && out_ready;
      mon_front = '0;
      if (mon_hs) begin
        if (occ == 0) begin
          checkOutput("spurious_result", 64'(out_valid), 64'(0));
          mon_hs = 1'b0;
        end else begin
          mon_front = sb.pop_front();
          checkOutput("sb_data", 64'(data_out), 64'(mon_front.data));
          checkOutput("sb_sgl", 64'(err_sgl), 64'(mon_front.sgl));
          checkOutput("sb_dbl", 64'(err_dbl), 64'(mon_front.dbl));
          checkOutput("sb_pos", 64'(err_pos), 64'(mon_front.pos));
        end
      end
      if (rst || clr_cnt) begin
        m_cnt_sgl   = '0;
        m_cnt_dbl   = '0;
        m_log_valid = 1'b0;
        m_log_code  = '0;
      end else if (mon_hs) begin
        if (mon_front.sgl && m_cnt_sgl != CNT_MAX) m_cnt_sgl = m_cnt_sgl + 1'b1;
        if (mon_front.dbl && m_cnt_dbl != CNT_MAX) m_cnt_dbl = m_cnt_dbl + 1'b1;
        if (mon_front.dbl && !m_log_valid) begin
          m_log_valid = 1'b1;
          m_log_code  = mon_front.code;
        end
      end
      if (rst) sb.delete();
      else if (in_valid && exp_ir) sb.push_back(drv_exp);
      hold_pending = !rst && out_valid && !out_ready;
      hold_data = data_out;
      hold_sgl  = err_sgl;
      hold_dbl  = err_dbl;
      hold_pos  = err_pos;
    end
  end

  task automatic runStream(input int n, input bit bubbles, input bit rand_clr);
    int sent;
    int guard;
    bit acc;
    sent = 0;
    guard = 0;
    while ((sent < n || sb.size() != 0) && guard < 4000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      clr_cnt = rand_clr && ($urandom_range(0, 19) == 0);
      if (sent < n && !in_valid && (!bubbles || $urandom_range(0, 3) != 0))
        applyStimulus(makeWord());
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      guard++;
    end
    checkOutput("stream_sent", 64'(sent), 64'(n));
    checkOutput("stream_drained", 64'(sb.size()), 64'(0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr_cnt = 1'b0;
    tick();
  endtask

  initial begin
    tbl[0] = '{code: 13'h144E, data: 8'hA5, sgl: 1'b0, dbl: 1'b0, pos: 4'd0};
    tbl[1] = '{code: 13'h140E, data: 8'hA5, sgl: 1'b1, dbl: 1'b0, pos: 4'd6};
    tbl[2] = '{code: 13'h144F, data: 8'hA5, sgl: 1'b1, dbl: 1'b0, pos: 4'd0};
    tbl[3] = '{code: 13'h1406, data: 8'hA0, sgl: 1'b0, dbl: 1'b1, pos: 4'd0};
    tbl[4] = '{code: 13'h0442, data: 8'h24, sgl: 1'b0, dbl: 1'b1, pos: 4'd0};
    tbl[5] = '{code: 13'h0000, data: 8'h00, sgl: 1'b0, dbl: 1'b0, pos: 4'd0};
    tbl[6] = '{code: 13'h144C, data: 8'hA5, sgl: 1'b1, dbl: 1'b0, pos: 4'd1};
    tbl[7] = '{code: 13'h044E, data: 8'hA5, sgl: 1'b1, dbl: 1'b0, pos: 4'd12};

    rst = 1'b1;
    in_valid = 1'b0;
    code_in = '0;
    out_ready = 1'b1;
    clr_cnt = 1'b0;
    drv_exp = '0;
    repeat (3) tick();
    checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_data", 64'(data_out), 64'(0));
    checkOutput("rst_sgl", 64'(err_sgl), 64'(0));
    checkOutput("rst_dbl", 64'(err_dbl), 64'(0));
    checkOutput("rst_pos", 64'(err_pos), 64'(0));
    checkOutput("rst_cnt_sgl", 64'(cnt_sgl), 64'(0));
    checkOutput("rst_cnt_dbl", 64'(cnt_dbl), 64'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i]);
      checkOutput("tbl_in_ready", 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      checkOutput("tbl_lat1_valid", 64'(out_valid), 64'(0));
      tick();
      checkOutput("tbl_lat2_valid", 64'(out_valid), 64'(1));
      checkOutput("tbl_data", 64'(data_out), 64'(tbl[i].data));
      checkOutput("tbl_sgl", 64'(err_sgl), 64'(tbl[i].sgl));
      checkOutput("tbl_dbl", 64'(err_dbl), 64'(tbl[i].dbl));
      checkOutput("tbl_pos", 64'(err_pos), 64'(tbl[i].pos));
      tick();
    end

    $display("[TB] counter saturation");
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checkOutput("clr_cnt_sgl", 64'(cnt_sgl), 64'(0));
    checkOutput("clr_cnt_dbl", 64'(cnt_dbl), 64'(0));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(tbl[1]);
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      checkOutput("sat_cnt_sgl", 64'(cnt_sgl), (i >= 2) ? 64'(3) : 64'(i + 1));
    end

    $display("[TB] clear coincident with error handshake");
    applyStimulus(tbl[1]);
    tick();
    in_valid = 1'b0;
    tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checkOutput("clr_wins_cnt_sgl", 64'(cnt_sgl), 64'(0));

    $display("[TB] back-to-back stream under random backpressure");
    runStream(8, 1'b0, 1'b0);
    $display("[TB] long random stream");
    runStream(300, 1'b1, 1'b1);

    $display("[TB] reset mid-stream");
    applyStimulus(tbl[3]);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    out_ready = 1'b0;
    applyStimulus(tbl[1]);
    repeat (3) tick();
    checkOutput("full_stall_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b1;
    checkOutput("midrst_in_ready", 64'(in_ready), 64'(0));
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("midrst_cnt_sgl", 64'(cnt_sgl), 64'(0));
    checkOutput("midrst_cnt_dbl", 64'(cnt_dbl), 64'(0));
    repeat (3) tick();
    checkOutput("midrst_no_result", 64'(out_valid), 64'(0));

    applyStimulus(tbl[0]);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("recover_valid", 64'(out_valid), 64'(1));
    checkOutput("recover_data", 64'(data_out), 64'(8'hA5));
    repeat (2) tick();
    checkOutput("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
